// File: rtl/mem_copy_pkg.sv
// Shared widths and FSM state encoding for the block-copy initiator.
package mem_copy_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/mem_copy_if.sv
// Single-port data memory bus: the copy engine is master, data_mem (or its mux) is slave.
interface mem_copy_if #(
  parameter int ADDR_W = mem_copy_pkg::ADDR_W,
  parameter int DATA_W = mem_copy_pkg::DATA_W
) ();
  logic [ADDR_W-1:0] DataAddress;
  logic              ReadMem;
  logic              WriteMem;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] DataOut;

  modport master (output DataAddress, ReadMem, WriteMem, DataIn, input DataOut);
  modport slave  (input DataAddress, ReadMem, WriteMem, DataIn, output DataOut);
endinterface

// File: rtl/mem_copy.sv
// Block-copy DMA master: copies Len bytes Src->Dst, one read cycle then one write cycle per byte.
// Optional running byte checksum of copied data when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy #(
  parameter int ADDR_W = mem_copy_pkg::ADDR_W,
  parameter int DATA_W = mem_copy_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Len,
  output logic              busy,
  output logic              done,
  mem_copy_if.master        mem
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] Checksum
`endif
);
  import mem_copy_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] hold;

  assign cnt_nxt         = cnt + ADDR_W'(1);
  assign mem.DataAddress = addr;
  assign mem.ReadMem     = rd;
  assign mem.WriteMem    = wr;
  // hold is only presented on the bus while writing, keeping DataIn zero elsewhere
  assign mem.DataIn      = wr ? hold : '0;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      src      <= '0;
      dst      <= '0;
      len      <= '0;
      cnt      <= '0;
      addr     <= '0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      hold     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
      Checksum <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src  <= SrcAddr;
            dst  <= DstAddr;
            len  <= Len;
            cnt  <= '0;
            busy <= 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
            Checksum <= '0;
`endif
            if (Len != '0) begin
              state <= READ;
              rd    <= 1'b1;
              addr  <= SrcAddr;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          hold  <= mem.DataOut;
          rd    <= 1'b0;
          wr    <= 1'b1;
          addr  <= dst + cnt;
          state <= WRITE;
        end
        WRITE: begin
          cnt <= cnt_nxt;
          wr  <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
          Checksum <= Checksum + hold;
`endif
          if (cnt_nxt == len) begin
            state <= DONE;
            done  <= 1'b1;
            addr  <= '0;
          end else begin
            state <= READ;
            rd    <= 1'b1;
            addr  <= src + cnt_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_copy.sv
// Scoreboard bench for mem_copy: a forward byte-copy model predicts every read, write and done pulse.
`timescale 1ns/1ps
module tb_mem_copy;
  import mem_copy_pkg::*;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] SrcAddr, DstAddr, Len;
  logic       busy, done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0] Checksum;
`endif

  mem_copy_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_copy #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .start   (start),
    .SrcAddr (SrcAddr),
    .DstAddr (DstAddr),
    .Len     (Len),
    .busy    (busy),
    .done    (done),
    .mem     (bus)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .Checksum(Checksum)
`endif
  );

  always #5 CLK = ~CLK;

  // memory behind the port, plus a side door for preloading
  logic [7:0] mem [256];
  logic       pl_we;
  logic [7:0] pl_addr, pl_dat;
  assign bus.DataOut = mem[bus.DataAddress];
  always @(posedge CLK) begin
    if (pl_we) mem[pl_addr] <= pl_dat;
    else if (bus.WriteMem) mem[bus.DataAddress] <= bus.DataIn;
  end

  typedef struct {int cyc; logic [7:0] addr; logic [7:0] dat;} acc_t;
  logic [7:0] model_mem [256];
  acc_t       rd_q[$];
  acc_t       wr_q[$];
  int         done_q[$];
  logic [7:0] exp_csum = 8'd0;
  logic [7:0] held_csum = 8'd0;
  int  n_chk = 0, n_fail = 0;
  int  edge_cnt = 0, e0 = 0, cur_len = 0;
  bit  active = 1'b0;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT output with nothing expected (t=%0t)", name, $time);
  endtask

  // Reference: byte k read in cycle 2k+1, written in 2k+2, done in 2N+1; only events up to limit happen.
  function automatic void push_copy(input logic [7:0] s, input logic [7:0] d, input int l, input int limit);
    logic [7:0] sum;
    sum = 8'd0;
    for (int k = 0; k < l; k++) begin
      logic [7:0] sa, da, b;
      sa = s + 8'(k);
      da = d + 8'(k);
      b  = model_mem[sa];
      if (2*k+1 <= limit) rd_q.push_back('{2*k+1, sa, 8'h00});
      if (2*k+2 <= limit) begin
        wr_q.push_back('{2*k+2, da, b});
        model_mem[da] = b;
        sum = sum + b;
      end
    end
    if (2*l+1 <= limit) done_q.push_back(2*l+1);
    exp_csum = sum;
  endfunction

  always @(negedge CLK) begin
    int   cyc;
    acc_t a;
    int   dc;
    cyc = edge_cnt - e0 + 1;
    check("rd_wr_excl", {31'd0, bus.ReadMem & bus.WriteMem}, 0);
    if (!bus.WriteMem) check("datain_zero", {24'd0, bus.DataIn}, 0);
    if (!bus.ReadMem && !bus.WriteMem) check("addr_zero", {24'd0, bus.DataAddress}, 0);
    check("busy", {31'd0, busy}, {31'd0, active && cyc >= 1 && cyc <= 2*cur_len+1});
    if (bus.ReadMem) begin
      if (rd_q.size() == 0) unexpected("read");
      else begin
        a = rd_q.pop_front();
        check("rd_addr", {24'd0, bus.DataAddress}, {24'd0, a.addr});
        check("rd_cycle", cyc, a.cyc);
      end
    end
    if (bus.WriteMem) begin
      if (wr_q.size() == 0) unexpected("write");
      else begin
        a = wr_q.pop_front();
        check("wr_addr", {24'd0, bus.DataAddress}, {24'd0, a.addr});
        check("wr_data", {24'd0, bus.DataIn}, {24'd0, a.dat});
        check("wr_cycle", cyc, a.cyc);
      end
    end
    if (done) begin
      if (done_q.size() == 0) unexpected("done");
      else begin
        dc = done_q.pop_front();
        check("done_cycle", cyc, dc);
`ifdef MEM_COPY_CHECKSUM_EN
        check("checksum", {24'd0, Checksum}, {24'd0, exp_csum});
`endif
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    model_mem[a] = d;
    @(posedge CLK); #1;
    pl_we = 1'b0;
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((rd_q.size() + wr_q.size() + done_q.size()) != 0 && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    check("drain", rd_q.size() + wr_q.size() + done_q.size(), 0);
    rd_q.delete(); wr_q.delete(); done_q.delete();
  endtask

  // Called just after a posedge with the DUT in IDLE; start is accepted at the next edge.
  task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l, input int limit);
`ifdef MEM_COPY_CHECKSUM_EN
    check("csum_hold", {24'd0, Checksum}, {24'd0, held_csum});
`endif
    push_copy(s, d, int'(l), limit);
    start = 1'b1; SrcAddr = s; DstAddr = d; Len = l;
    @(posedge CLK); #1;
    e0 = edge_cnt; cur_len = int'(l); active = 1'b1;
    start = 1'b0; SrcAddr = 8'($urandom); DstAddr = 8'($urandom); Len = 8'($urandom);
  endtask

  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l, input string name);
    issue(s, d, l, 100000);
    wait_drain(2*int'(l) + 8);
    held_csum = exp_csum;
    check_mem(name);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; SrcAddr = 8'd0; DstAddr = 8'd0; Len = 8'd0;
    pl_we = 1'b0; pl_addr = 8'd0; pl_dat = 8'd0;
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_rd", {31'd0, bus.ReadMem}, 0);
    check("rst_wr", {31'd0, bus.WriteMem}, 0);
    check("rst_addr", {24'd0, bus.DataAddress}, 0);
    check("rst_din", {24'd0, bus.DataIn}, 0);
`ifdef MEM_COPY_CHECKSUM_EN
    check("rst_csum", {24'd0, Checksum}, 0);
`endif
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));

    preload(8'd16, 8'd254); preload(8'd17, 8'd7); preload(8'd18, 8'd9);
    run_copy(8'd16, 8'd100, 8'd3, "mem_basic");
    check("m100", {24'd0, mem[100]}, 254);
    check("m101", {24'd0, mem[101]}, 7);
    check("m102", {24'd0, mem[102]}, 9);
`ifdef MEM_COPY_CHECKSUM_EN
    check("csum_14", {24'd0, Checksum}, 14);
`endif

    run_copy(8'd5, 8'd6, 8'd0, "mem_len0");

    preload(8'd254, 8'd1); preload(8'd255, 8'd2); preload(8'd0, 8'd3); preload(8'd1, 8'd4);
    run_copy(8'd254, 8'd0, 8'd4, "mem_wrap");
    check("wrap_m0", {24'd0, mem[0]}, 1);
    check("wrap_m1", {24'd0, mem[1]}, 2);
    check("wrap_m2", {24'd0, mem[2]}, 1);
    check("wrap_m3", {24'd0, mem[3]}, 2);

    // start pulsed again in cycle 3 must be dropped
    issue(8'd30, 8'd60, 8'd2, 100000);
    repeat (2) @(posedge CLK); #1;
    start = 1'b1; SrcAddr = 8'd200; DstAddr = 8'd210; Len = 8'd1;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_drain(12);
    held_csum = exp_csum;
    repeat (6) @(posedge CLK); #1;
    check_mem("mem_ignored_start");

    // reset in cycle 4 of a 4-byte copy: only byte 0 lands
    issue(8'd40, 8'd140, 8'd4, 3);
    repeat (3) @(posedge CLK); #1;
    reset = 1'b1; active = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_rd", {31'd0, bus.ReadMem}, 0);
    check("abort_wr", {31'd0, bus.WriteMem}, 0);
    check("abort_addr", {24'd0, bus.DataAddress}, 0);
`ifdef MEM_COPY_CHECKSUM_EN
    check("abort_csum", {24'd0, Checksum}, 0);
`endif
    held_csum = 8'd0;
    repeat (2) @(posedge CLK); #1;
    reset = 1'b0;
    check("abort_pending", rd_q.size() + wr_q.size() + done_q.size(), 0);
    rd_q.delete(); wr_q.delete(); done_q.delete();
    check_mem("mem_abort");
    run_copy(8'd41, 8'd150, 8'd1, "mem_after_abort");

    for (int i = 0; i < 12; i++) begin
      logic [7:0] l;
      l = (i == 0) ? 8'd255 : 8'($urandom_range(0, 24));
      run_copy(8'($urandom), 8'($urandom), l, "mem_random");
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_copy.md
# mem_copy

Block-copy initiator that drives the single-port data memory interface (DataAddress, ReadMem, WriteMem, DataIn, DataOut) from the other side. On a start pulse it copies Len bytes from SrcAddr onward to DstAddr onward, one byte per two cycles: a combinational read followed by a clocked write. It sits between the datapath's control logic and data_mem as a simple DMA master, so the core can offload bulk moves. It multiplexes onto the memory port upstream.

## Interface
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 8, memory data width
- CLK  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- SrcAddr  in  ADDR_W  first source address, captured on accepted start
- DstAddr  in  ADDR_W  first destination address, captured on accepted start
- Len  in  ADDR_W  byte count 0..255, captured on accepted start
- busy  out  1  high in READ, WRITE and DONE
- done  out  1  one-cycle pulse in DONE
- DataAddress  out  ADDR_W  memory address
- ReadMem  out  1  memory read enable
- WriteMem  out  1  memory write enable
- DataIn  out  DATA_W  memory write data
- DataOut  in  DATA_W  memory read data, combinational from DataAddress
- Checksum  out  DATA_W  only with MEM_COPY_CHECKSUM_EN

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: start=1 captures SrcAddr, DstAddr and Len, and clears the byte counter. Next state is READ if Len≠0, otherwise DONE.
- READ: ReadMem=1, DataAddress=src+cnt. At the edge, DataOut is latched into the hold register. Next state is WRITE.
- WRITE: WriteMem=1, DataAddress=dst+cnt, DataIn=hold. At the edge, cnt is incremented. Next state is DONE if cnt+1==Len, otherwise READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- ReadMem and WriteMem are never high together.
- Outside their own state, DataAddress, DataIn, ReadMem and WriteMem are 0.
- Address sums are ADDR_W bits and wrap: src=250, Len=10 reads 250..255, then 0..3.
- Overlapping ranges are copied strictly forward, byte by byte. With dst>src, source bytes already overwritten propagate; this is the defined behaviour.
- start while busy is ignored; it is not queued.
- Input changes after start has been accepted have no effect.

## Timing
- Reset (asynchronous): state=IDLE; busy, done, ReadMem, WriteMem = 0; DataAddress, DataIn, hold, counter, Checksum = 0.
- Reset asserted mid-copy aborts immediately. Bytes already written stay in memory; no done pulse is issued.
- Let edge 0 be the edge that accepts start. For Len=N≥1:
  - byte k is in READ during cycle 2k+1 and in WRITE during cycle 2k+2;
  - done is high in cycle 2N+1;
  - IDLE is re-entered at cycle 2N+2.
- Len=0: done is high in cycle 1, with no memory access.
- A new start is accepted at the earliest in the first IDLE cycle after DONE.

## Configuration
- MEM_COPY_CHECKSUM_EN defined:
  - Checksum port exists.
  - Checksum is cleared on an accepted start.
  - In each WRITE cycle it adds the hold register, modulo 2^DATA_W, at the edge.
  - It holds its value after DONE until the next start or reset.
- Undefined: the Checksum port and its register are absent; all other behaviour is identical.

## Structure
- Package mem_copy_pkg holds ADDR_W and DATA_W defaults and typedef enum logic [1:0] state_t {IDLE, READ, WRITE, DONE}.
- No sub-module. The FSM, counter, address adders, hold register and optional checksum fit in one module.

## Test plan
- Preload M[16]=254, M[17]=7, M[18]=9. start with Src=16, Dst=100, Len=3 -> M[100..102]=254,7,9; done in cycle 7; Checksum=14 (270 mod 256) when enabled.
- Len=0, Src=5, Dst=6 -> done in cycle 1; ReadMem and WriteMem never asserted; memory unchanged.
- Wrap-around: Src=254, Dst=0, Len=4, with M[254]=1, M[255]=2, M[0]=3, M[1]=4. Writes go to 0..3; reads 254, 255, 0 (already 1), 1 (already 2) -> M[0..3]=1,2,1,2.
- start pulsed again in cycle 3 of a Len=2 copy -> ignored; exactly one done pulse in cycle 5; no second transfer.
- reset asserted in cycle 4 of a Len=4 copy -> outputs 0 immediately; only byte 0 written; no done; a following start with Len=1 completes normally in 3 cycles.
- Protocol checker across all runs: ReadMem and WriteMem never high together; DataAddress, DataIn and both enables are 0 in IDLE and DONE.
